amo_unit: RTL

//  RV32A atomic sequencer beside the LSU in the MEM stage. Runs LR.W, SC.W and AMO*.W as load/store

---
 rtl/amo_if.sv | 32 +++
 rtl/amo_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/amo_if.sv
// Bus bundle between the MEM-stage LSU and the RV32A atomic sequencer.
// The slave modport is the amo_unit side; the master modport is the LSU/pipeline side.
interface amo_if #(
   parameter int XLEN = 32
);
   logic            is_amo_i;
   logic [3:0]      amo_ops_i;
   logic            amo_flush_i;
   logic            ack_i;
   logic [XLEN-1:0] lsu_addr_i;
   logic [XLEN-1:0] rs2_operand_i;
   logic [XLEN-1:0] r_data_i;
   logic            rsv_clr_i;
   logic            ld_req_o;
   logic            st_req_o;
   logic [XLEN-1:0] w_data_o;
   logic            rd_wr_req_o;
   logic            amo_done_o;
   logic [XLEN-1:0] amo_wrb_data_o;

   modport slave (
      input  is_amo_i, amo_ops_i, amo_flush_i, ack_i, lsu_addr_i,
             rs2_operand_i, r_data_i, rsv_clr_i,
      output ld_req_o, st_req_o, w_data_o, rd_wr_req_o, amo_done_o, amo_wrb_data_o
   );

   modport master (
      output is_amo_i, amo_ops_i, amo_flush_i, ack_i, lsu_addr_i,
             rs2_operand_i, r_data_i, rsv_clr_i,
      input  ld_req_o, st_req_o, w_data_o, rd_wr_req_o, amo_done_o, amo_wrb_data_o
   );
endinterface

// File: rtl/amo_unit.sv
// RV32A atomic sequencer: runs LR.W/SC.W/AMO*.W as load/store sequences and holds the reservation.
// Optional reservation lifetime counter enabled by defining AMO_RSV_TIMEOUT_EN.
module amo_unit #(
   parameter int XLEN        = 32,
   parameter int RSV_LSB     = 2,
   parameter int RSV_TIMEOUT = 64
) (
   input logic  clk,
   input logic  rst_n,
   amo_if.slave bus
);
   localparam logic [3:0] OP_LR   = 4'd1;
   localparam logic [3:0] OP_SC   = 4'd2;
   localparam logic [3:0] OP_SWAP = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;
   localparam logic [3:0] OP_MIN  = 4'd8;
   localparam logic [3:0] OP_MAX  = 4'd9;
   localparam logic [3:0] OP_MINU = 4'd10;
   localparam logic [3:0] OP_MAXU = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic                  rsv_valid_q, rsv_valid_d;
   logic [XLEN-1:RSV_LSB] rsv_addr_q, rsv_addr_d;
   logic [XLEN-1:0]       old_q, old_d;
   logic [XLEN-1:0]       wrb_q, wrb_d;
   logic [3:0]            op_q, op_d;
   logic                  flushed_q, flushed_d;
   logic                  rsv_hit_s;

`ifdef AMO_RSV_TIMEOUT_EN
   localparam int CNT_W = $clog2(RSV_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign rsv_hit_s = rsv_valid_q && (cnt_q != {CNT_W{1'b0}}) &&
                      (bus.lsu_addr_i[XLEN-1:RSV_LSB] == rsv_addr_q);
`else
   assign rsv_hit_s = rsv_valid_q && (bus.lsu_addr_i[XLEN-1:RSV_LSB] == rsv_addr_q);
`endif

   // Store-data function; MIN/MAX variants keep old on a tie.
   function automatic logic [XLEN-1:0] amo_alu(input logic [3:0] op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] rs2);
      case (op)
         OP_ADD:  amo_alu = old + rs2;
         OP_XOR:  amo_alu = old ^ rs2;
         OP_AND:  amo_alu = old & rs2;
         OP_OR:   amo_alu = old | rs2;
         OP_MIN:  amo_alu = ($signed(rs2) < $signed(old)) ? rs2 : old;
         OP_MAX:  amo_alu = ($signed(rs2) > $signed(old)) ? rs2 : old;
         OP_MINU: amo_alu = (rs2 < old) ? rs2 : old;
         OP_MAXU: amo_alu = (rs2 > old) ? rs2 : old;
         default: amo_alu = rs2;
      endcase
   endfunction

   assign bus.ld_req_o       = (state_q == S_LOAD);
   assign bus.st_req_o       = (state_q == S_STORE);
   assign bus.amo_done_o     = (state_q == S_DONE);
   assign bus.rd_wr_req_o    = (state_q == S_DONE);
   assign bus.amo_wrb_data_o = wrb_q;
   assign bus.w_data_o       = (state_q == S_STORE) ? amo_alu(op_q, old_q, bus.rs2_operand_i)
                                                    : {XLEN{1'b0}};

   // Next-state, reservation and data-register update.
   always_comb begin
      state_d     = state_q;
      rsv_valid_d = rsv_valid_q;
      rsv_addr_d  = rsv_addr_q;
      old_d       = old_q;
      wrb_d       = wrb_q;
      op_d        = op_q;
      flushed_d   = flushed_q;
`ifdef AMO_RSV_TIMEOUT_EN
      cnt_d = cnt_q;
      if (rsv_valid_q) begin
         if (cnt_q == {CNT_W{1'b0}}) begin
            rsv_valid_d = 1'b0;
         end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_d = cnt_q;
      end
`endif
      case (state_q)
         S_IDLE: begin
            flushed_d = 1'b0;
            if (bus.is_amo_i && !bus.amo_flush_i) begin
               op_d = bus.amo_ops_i;
               if (bus.amo_ops_i == OP_LR) begin
                  state_d = S_LOAD;
               end else if (bus.amo_ops_i == OP_SC) begin
                  if (rsv_hit_s) begin
                     state_d = S_STORE;
                  end else begin
                     state_d     = S_DONE;
                     wrb_d       = {{(XLEN-1){1'b0}}, 1'b1};
                     rsv_valid_d = 1'b0;
                  end
               end else if ((bus.amo_ops_i >= OP_SWAP) && (bus.amo_ops_i <= OP_MAXU)) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (bus.amo_flush_i) begin
               state_d = S_IDLE;
            end else if (bus.ack_i) begin
               wrb_d = bus.r_data_i;
               if (op_q == OP_LR) begin
                  rsv_valid_d = 1'b1;
                  rsv_addr_d  = bus.lsu_addr_i[XLEN-1:RSV_LSB];
`ifdef AMO_RSV_TIMEOUT_EN
                  cnt_d = CNT_W'(RSV_TIMEOUT);
`endif
                  state_d = S_DONE;
               end else begin
                  old_d   = bus.r_data_i;
                  state_d = S_STORE;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_STORE: begin
            // A flush here cannot cancel the store, only the completion pulse.
            if (bus.ack_i) begin
               if (op_q == OP_SC) begin
                  wrb_d = {XLEN{1'b0}};
               end else begin
                  wrb_d = wrb_q;
               end
               rsv_valid_d = 1'b0;
               flushed_d   = 1'b0;
               state_d     = (flushed_q || bus.amo_flush_i) ? S_IDLE : S_DONE;
            end else begin
               flushed_d = flushed_q | bus.amo_flush_i;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      rsv_valid_d = rsv_valid_d & ~bus.rsv_clr_i;
   end

   // State and data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rsv_valid_q <= 1'b0;
         rsv_addr_q  <= {(XLEN-RSV_LSB){1'b0}};
         old_q       <= {XLEN{1'b0}};
         wrb_q       <= {XLEN{1'b0}};
         op_q        <= 4'd0;
         flushed_q   <= 1'b0;
`ifdef AMO_RSV_TIMEOUT_EN
         cnt_q       <= {CNT_W{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         rsv_valid_q <= rsv_valid_d;
         rsv_addr_q  <= rsv_addr_d;
         old_q       <= old_d;
         wrb_q       <= wrb_d;
         op_q        <= op_d;
         flushed_q   <= flushed_d;
`ifdef AMO_RSV_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end
endmodule
